// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between the IF and MEM pipeline stages.
// MEM stage has priority; a starvation counter forces an IF grant after STARVE_MAX MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic             owner_d;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;
    logic [ST_W-1:0]  starve_cnt;
    logic             flush_pend;

    logic if_forced;
    logic grant_d;
    logic any_req;
    logic last_beat;
    logic flush_now;

    always_comb begin
        if_forced = if_req && (starve_cnt == ST_W'(STARVE_MAX));
        grant_d   = d_req && !if_forced;
        any_req   = if_req || d_req;
        last_beat = (cnt == CNT_W'(MEM_LAT - 1));
        // Includes a flush arriving in the final ACCESS cycle itself.
        flush_now = flush_pend || (if_flush && !owner_d);
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            starve_cnt <= '0;
            flush_pend <= 1'b0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (!if_req)
                starve_cnt <= '0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d  <= grant_d;
                        lat_we   <= grant_d & d_we;
                        mem_we   <= grant_d & d_we;
                        mem_en   <= 1'b1;
                        cnt      <= '0;
                        state    <= ACCESS;
                        if (grant_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (if_req && starve_cnt != ST_W'(STARVE_MAX))
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            mem_addr   <= if_addr;
                            starve_cnt <= '0;
                            flush_pend <= if_flush;
                        end
                    end
                end

                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (!owner_d && if_flush)
                        flush_pend <= 1'b1;
                    if (last_beat) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= RESP;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!lat_we)
                                d_rdata <= mem_rdata;
                        end else if (!flush_now) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end

                RESP: begin
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
